ps2_kb_controller: RTL and testbench
====================================

// Module: ps2_kb_controller
// PURPOSE
//  Receive-side controller for the PS/2 keyboard port on the Basys board.
//  Oversamples clk_kb/data_kb on the system clock and frames each 11-bit PS/2 packet.
//  Checks parity, stop bit and an inter-edge timeout, and decodes E0/F0 prefixes into key events.
//  Buffers events in a FIFO with a valid/ready interface for the rest of the design.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency, Hz
//  TIMEOUT_US  2000         maximum gap between PS/2 falling edges inside a frame, us
//  FIFO_DEPTH  8            event FIFO entries; must be a power of 2, >= 2
//  SYNC_STAGES 2            synchronizer flops on clk_kb and data_kb, >= 2
// PORTS
//  clk        in   1  system clock; every flop in the block is clocked by clk
//  rst        in   1  synchronous, active-high reset
//  clk_kb     in   1  PS/2 clock from keyboard (asynchronous)
//  data_kb    in   1  PS/2 data from keyboard (asynchronous)
//  evt_code   out  8  scan code at FIFO head
//  evt_brk    out  1  head event is a release (F0 prefix)
//  evt_ext    out  1  head event is extended (E0 prefix)
//  evt_valid  out  1  FIFO not empty
//  evt_ready  in   1  consumer accepts head when evt_valid&&evt_ready
//  last_key   out  8  code of the currently held key; 0 when none
//  frame_err  out  1  1-cycle pulse on parity, stop or timeout error
//  fifo_ovf   out  1  sticky; set on a dropped event, cleared only by rst
// BEHAVIOUR
//  - Reset: all outputs 0, frame FSM IDLE, prefix flags clear, FIFO empty, timeout counter 0.
//    rst mid-frame discards the partial frame.
//  - Edge detect: a falling edge is sync(clk_kb) previously 1, now 0.
//    data_kb is sampled from its synchronizer in the same cycle.
//  - Frame FSM, advanced only on falling edges:
//    IDLE -> START: data 0 enters SHIFT with bitcnt=0; data 1 is ignored and the FSM stays in IDLE.
//    SHIFT: captures 8 bits LSB first, then goes to PARITY.
//    PARITY: captures the parity bit; the 9 bits must have an odd count of 1s.
//    STOP: captures the stop bit (must be 1); returns to IDLE.
//    On STOP: if parity and stop are good, byte_valid pulses for 1 cycle;
//    otherwise frame_err pulses for 1 cycle and the byte is dropped.
//  - Timeout: counter clears on every falling edge and on entry to IDLE.
//    Outside IDLE, when it reaches CLK_HZ/1e6*TIMEOUT_US: frame_err pulse, FSM -> IDLE.
//  - Decoder, on byte_valid:
//    0xE0 sets pend_ext. 0xF0 sets pend_brk.
//    Any other byte (incl. E1, AA, FA) pushes {pend_ext,pend_brk,byte} and clears both flags.
//  - last_key: a make event loads code; a break event whose code equals last_key clears it to 0.
//  - FIFO: first-word-fall-through; 10-bit entries.
//    evt_valid rises 2 clk after the cycle the stop-bit edge is detected (FIFO empty).
//    Pop when evt_valid&&evt_ready.
//    Push while full: event dropped, fifo_ovf<=1, contents unchanged.
//    Simultaneous push and pop when full: pop and push both succeed, no overflow.
//    Pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
// CONFIGURATION
//  KB_REPEAT_FILTER_EN defined:
//    A make event whose {ext,code} equals the held key ({held_ext,last_key}, last_key!=0)
//    is not pushed, so typematic repeats are suppressed; the break clears the held key.
//  KB_REPEAT_FILTER_EN undefined:
//    Every make is pushed, including repeats; no held_ext flop.
// TESTING
//  1. Frame 0x1C, parity 0, stop 1 -> one event {ext0,brk0,0x1C}; last_key=0x1C; frame_err stays 0.
//  2. 0x1C, then F0, 1C -> second event {0,1,0x1C}; last_key=0; F0 alone pushes nothing.
//  3. E0 75, then E0 F0 75 -> events {1,0,0x75} and {1,1,0x75}, in order.
//  4. 0x1C with parity 1 -> frame_err 1-cycle pulse, no event.
//     Then stop clk_kb after 5 bits for > TIMEOUT_US -> frame_err pulse.
//     A following good 0x1C frame decodes normally.
//  5. evt_ready=0, send make codes 0x15..0x1D (9 events), FIFO_DEPTH 8 -> 8 entries, fifo_ovf=1.
//     Raising evt_ready pops 0x15 first, 0x1C last; 0x1D is lost.
//  6. 1C,1C,1C,F0,1C -> with KB_REPEAT_FILTER_EN: 2 events (make, break); without: 4 events.
//  Also: rst asserted mid-SHIFT -> all outputs 0, next frame decodes cleanly.

Source files
------------

// File: rtl/ps2_kb_controller.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, frames 11-bit packets, decodes E0/F0 prefixes
// and queues key events in a FWFT FIFO. Optional typematic-repeat filter: KB_REPEAT_FILTER_EN.
module ps2_kb_controller #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_kb,
    input  logic       data_kb,
    output logic [7:0] evt_code,
    output logic       evt_brk,
    output logic       evt_ext,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] last_key,
    output logic       frame_err,
    output logic       fifo_ovf
);

    localparam int TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    function automatic logic odd_parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   fall_s, din_s;

    logic [1:0]      state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            parity_q, parity_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    logic            pend_ext_q, pend_brk_q;
    logic [7:0]      last_key_q;
    logic            fifo_ovf_q;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [PW:0]     wr_q, rd_q;

    logic            evt_s, repeat_s, push_s, pop_s, wr_en_s, full_s, empty_s;

    // Line synchronizers; reset to the idle-high level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], clk_kb};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_kb};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall_s = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign din_s  = data_sync_q[SYNC_STAGES-1];

    // Frame FSM and inter-edge timeout; a falling edge always wins over an expiring timeout.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        parity_d     = parity_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (fall_s && !din_s) begin
                    state_d  = ST_SHIFT;
                    bitcnt_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (fall_s) begin
                    to_cnt_d = '0;
                    case (state_q)
                        ST_SHIFT: begin
                            shreg_d  = {din_s, shreg_q[7:1]};
                            bitcnt_d = bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                state_d = ST_PARITY;
                            end else begin
                                state_d = ST_SHIFT;
                            end
                        end
                        ST_PARITY: begin
                            parity_d = din_s;
                            state_d  = ST_STOP;
                        end
                        ST_STOP: begin
                            state_d = ST_IDLE;
                            if (odd_parity_ok({shreg_q, parity_q}) && din_s) begin
                                byte_valid_d = 1'b1;
                            end else begin
                                frame_err_d = 1'b1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else if (to_cnt_q == TO_LIM) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                    to_cnt_d    = '0;
                end else begin
                    to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end
        endcase
    end

    // Frame FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bitcnt_q     <= 3'd0;
            shreg_q      <= 8'h00;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign evt_s   = byte_valid_q && (shreg_q != 8'hE0) && (shreg_q != 8'hF0);
    assign empty_s = (wr_q == rd_q);
    assign full_s  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop_s   = !empty_s && evt_ready;
    assign push_s  = evt_s && !repeat_s;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign wr_en_s = push_s && (!full_s || pop_s);

`ifdef KB_REPEAT_FILTER_EN
    logic held_ext_q;

    assign repeat_s = !pend_brk_q && (last_key_q != 8'h00) && (last_key_q == shreg_q)
                      && (held_ext_q == pend_ext_q);

    // Extended flag of the held key, so E0-xx and xx are told apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_ext_q <= 1'b0;
        end else if (evt_s && !pend_brk_q) begin
            held_ext_q <= pend_ext_q;
        end else begin
            held_ext_q <= held_ext_q;
        end
    end
`else
    assign repeat_s = 1'b0;
`endif

    // Prefix decoder and held-key tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
            last_key_q <= 8'h00;
        end else if (byte_valid_q) begin
            if (shreg_q == 8'hE0) begin
                pend_ext_q <= 1'b1;
            end else if (shreg_q == 8'hF0) begin
                pend_brk_q <= 1'b1;
            end else begin
                pend_ext_q <= 1'b0;
                pend_brk_q <= 1'b0;
                if (!pend_brk_q) begin
                    last_key_q <= shreg_q;
                end else if (shreg_q == last_key_q) begin
                    last_key_q <= 8'h00;
                end else begin
                    last_key_q <= last_key_q;
                end
            end
        end else begin
            pend_ext_q <= pend_ext_q;
        end
    end

    // Event FIFO storage, pointers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            wr_q       <= '0;
            rd_q       <= '0;
            fifo_ovf_q <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_q[PW-1:0]] <= {pend_ext_q, pend_brk_q, shreg_q};
                wr_q                <= wr_q + {{PW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_q <= rd_q + {{PW{1'b0}}, 1'b1};
            end
            if (push_s && !wr_en_s) begin
                fifo_ovf_q <= 1'b1;
            end
        end
    end

    assign evt_code  = mem_q[rd_q[PW-1:0]][7:0];
    assign evt_brk   = mem_q[rd_q[PW-1:0]][8];
    assign evt_ext   = mem_q[rd_q[PW-1:0]][9];
    assign evt_valid = !empty_s;
    assign last_key  = last_key_q;
    assign frame_err = frame_err_q;
    assign fifo_ovf  = fifo_ovf_q;

endmodule

// File: tb/tb_ps2_kb_controller.sv
// Bench for ps2_kb_controller: directed scenarios plus randomized frames checked
// against an event-level reference model (queue of expected events, held key, error count).
module tb_ps2_kb_controller;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_kb = 1'b1;
    logic       data_kb = 1'b1;
    logic       evt_ready;
    logic [7:0] evt_code, last_key;
    logic       evt_brk, evt_ext, evt_valid, frame_err, fifo_ovf;

    int vectors = 0;
    int miscompares = 0;
    int err_cnt = 0;
    int pop_cnt = 0;
    int ready_mode = 1;
    logic err_prev = 1'b0;

    logic [9:0] exp_q [$];
    logic       m_ext = 1'b0, m_brk = 1'b0, m_held_ext = 1'b0, m_ovf = 1'b0;
    logic [7:0] m_last = 8'h00;
    int         m_err = 0;

    ps2_kb_controller #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .clk_kb(clk_kb), .data_kb(data_kb),
        .evt_code(evt_code), .evt_brk(evt_brk), .evt_ext(evt_ext), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .last_key(last_key), .frame_err(frame_err), .fifo_ovf(fifo_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one decoded byte at the key-event level.
    task automatic model_byte(input logic [7:0] b);
        logic suppress;
        suppress = 1'b0;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (!m_brk) begin
`ifdef KB_REPEAT_FILTER_EN
                if (m_last != 8'h00 && m_last == b && m_held_ext == m_ext) suppress = 1'b1;
`endif
                m_last = b;
                m_held_ext = m_ext;
            end else if (b == m_last) begin
                m_last = 8'h00;
            end
            if (!suppress) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
                else m_ovf = 1'b1;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        data_kb = b;
        #40 clk_kb = 1'b0;
        #80 clk_kb = 1'b1;
        #40;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        if (bad_par) m_err++;
        else model_byte(b);
        ps2_bit(1'b1);
        data_kb = 1'b1;
        #200;
    endtask

    task automatic checkpoint(input string tag);
        #100;
        check({tag, "_last_key"}, 32'(last_key), 32'(m_last));
        check({tag, "_fifo_ovf"}, 32'(fifo_ovf), 32'(m_ovf));
        check({tag, "_frame_err_cnt"}, 32'(err_cnt), 32'(m_err));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        #50;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    endtask

    task automatic all_zero(input string tag);
        check(tag, {17'd0, evt_code, evt_brk, evt_ext, evt_valid, last_key, frame_err, fifo_ovf}, 32'd0);
    endtask

    // Consumer ready driver.
    initial begin
        evt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: evt_ready = 1'b0;
                1: evt_ready = 1'b1;
                default: evt_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: pops against the model queue, frame_err pulse counting.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_err) begin
                    err_cnt++;
                    check("frame_err_one_cycle", 32'(err_prev), 32'd0);
                end
                if (evt_valid && evt_ready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0)
                        check("unexpected_evt", {22'd0, evt_ext, evt_brk, evt_code}, 32'h3FF_FFFF);
                    else
                        check("evt", {22'd0, evt_ext, evt_brk, evt_code}, {22'd0, exp_q.pop_front()});
                end
            end
            err_prev = frame_err;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        logic [7:0] codes [6];
        codes[0] = 8'h1C; codes[1] = 8'h75; codes[2] = 8'h15;
        codes[3] = 8'h1D; codes[4] = 8'hE1; codes[5] = 8'hAA;

        repeat (5) @(posedge clk);
        @(negedge clk);
        all_zero("reset_outputs");
        @(posedge clk);
        #1 rst = 1'b0;
        #100;

        // 1: single make
        send_frame(8'h1C, 1'b0);
        checkpoint("t1");
        drain("t1");

        // 2: break sequence; F0 alone yields no event
        send_frame(8'h1C, 1'b0);
        pc = pop_cnt;
        send_frame(8'hF0, 1'b0);
        check("t2_f0_no_event", 32'(pop_cnt - pc), 32'd0);
        check("t2_f0_evt_valid", 32'(evt_valid), 32'd0);
        send_frame(8'h1C, 1'b0);
        checkpoint("t2");
        drain("t2");

        // 3: extended make and break
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        checkpoint("t3");
        drain("t3");

        // 4: parity error, timeout, then a clean frame
        send_frame(8'h1C, 1'b1);
        checkpoint("t4_parity");
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        data_kb = 1'b1;
        #4000;
        m_err++;
        checkpoint("t4_timeout");
        send_frame(8'h1C, 1'b0);
        checkpoint("t4_recover");
        drain("t4");

        // 5: overflow with the consumer stalled
        ready_mode = 0;
        for (int i = 0; i < 9; i++) send_frame(8'(8'h15 + i), 1'b0);
        checkpoint("t5_full");
        check("t5_evt_valid", 32'(evt_valid), 32'd1);
        check("t5_head", 32'(evt_code), 32'h15);
        ready_mode = 1;
        drain("t5");

        // 6: typematic repeats then release
        pc = pop_cnt;
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain("t6");
`ifdef KB_REPEAT_FILTER_EN
        check("t6_event_count", 32'(pop_cnt - pc), 32'd2);
`else
        check("t6_event_count", 32'(pop_cnt - pc), 32'd4);
`endif
        checkpoint("t6");

        // reset in the middle of SHIFT
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        all_zero("midframe_reset_outputs");
        m_ext = 1'b0; m_brk = 1'b0; m_last = 8'h00; m_held_ext = 1'b0; m_ovf = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #100;
        send_frame(8'h1C, 1'b0);
        checkpoint("rst_recover");
        drain("rst");

        // randomized frames with a randomly stalling consumer
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 15) b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else b = codes[$urandom_range(0, 5)];
            send_frame(b, 1'($urandom_range(0, 9) == 0));
        end
        ready_mode = 1;
        drain("rand");
        checkpoint("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
